// File: rtl/rng_health_monitor.sv
// RNG consumer with continuous health tests (repetition count, adaptive proportion, stall
// timeout). Words that pass every test are forwarded one cycle after acceptance.
module rng_health_monitor #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_SAMPLES    = 256,
    parameter int RCT_CUTOFF     = 4,
    parameter int APT_WINDOW     = 64,
    parameter int APT_CUTOFF     = 20,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear,
    output logic                  generate_enable,
    input  logic [DATA_WIDTH-1:0] random_in,
    input  logic                  random_valid,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_valid,
    output logic [15:0]           sample_count,
    output logic                  busy,
    output logic                  done,
    output logic                  rct_fail,
    output logic                  apt_fail,
    output logic                  timeout_fail
);

    localparam int REP_W  = $clog2(RCT_CUTOFF + 1);
    localparam int WIN_W  = $clog2(APT_WINDOW + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [REP_W-1:0]  REP_ONE    = REP_W'(1);
    localparam logic [REP_W-1:0]  REP_CUT    = REP_W'(RCT_CUTOFF);
    localparam logic [WIN_W-1:0]  WIN_ONE    = WIN_W'(1);
    localparam logic [WIN_W-1:0]  WIN_MAX    = WIN_W'(APT_WINDOW);
    localparam logic [WIN_W-1:0]  APT_CUT    = WIN_W'(APT_CUTOFF);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_CUT   = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [16:0]       LAST_COUNT = 17'(NUM_SAMPLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] rct_word, ref_word;
    logic [REP_W-1:0]      rep, rep_next;
    logic [WIN_W-1:0]      win, win_next, match, match_next;
    logic [WAIT_W-1:0]     wait_cnt, wait_next;
    logic                  accept_p0, new_win, rct_hit, apt_hit, tmo_hit, word_fail, run_end_p0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage p0: test the incoming word against the running statistics
    always_comb begin
        accept_p0  = (state == RUN) && random_valid;
        rep_next   = (rep == '0 || random_in != rct_word) ? REP_ONE : rep + REP_ONE;
        new_win    = (win == '0) || (win == WIN_MAX);
        win_next   = new_win ? WIN_ONE : win + WIN_ONE;
        match_next = new_win ? WIN_ONE : ((random_in == ref_word) ? match + WIN_ONE : match);
        wait_next  = wait_cnt + WAIT_ONE;
        rct_hit    = accept_p0 && (rep_next == REP_CUT);
        apt_hit    = accept_p0 && (match_next == APT_CUT);
        tmo_hit    = (state == RUN) && !random_valid && (wait_next == WAIT_CUT);
        word_fail  = rct_hit || apt_hit;
        run_end_p0 = accept_p0 && (({1'b0, sample_count} + 17'd1) == LAST_COUNT);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                if (word_fail || tmo_hit) state_next = FAIL;
                else if (run_end_p0)      state_next = DONE;
            end
            DONE:    state_next = IDLE;
            FAIL:    if (clear) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    assign generate_enable = (state == RUN);
    assign busy            = (state == RUN);
    assign done            = (state == DONE);

    // Stage p1: registered statistics, forwarded word and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rct_word     <= '0;
            ref_word     <= '0;
            rep          <= '0;
            win          <= '0;
            match        <= '0;
            wait_cnt     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            sample_count <= '0;
            rct_fail     <= 1'b0;
            apt_fail     <= 1'b0;
            timeout_fail <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (state == IDLE && start) begin
                sample_count <= '0;
                rep          <= '0;
                win          <= '0;
                match        <= '0;
                wait_cnt     <= '0;
            end
            if (accept_p0) begin
                sample_count <= sat_inc16(sample_count);
                rep          <= rep_next;
                rct_word     <= random_in;
                win          <= win_next;
                match        <= match_next;
                wait_cnt     <= '0;
                if (new_win) ref_word <= random_in;
                if (!word_fail) begin
                    sample_out   <= random_in;
                    sample_valid <= 1'b1;
                end
            end else if (state == RUN) begin
                wait_cnt <= wait_next;
            end
            if (rct_hit) rct_fail     <= 1'b1;
            if (apt_hit) apt_fail     <= 1'b1;
            if (tmo_hit) timeout_fail <= 1'b1;
            if (state == FAIL && clear) begin
                rct_fail     <= 1'b0;
                apt_fail     <= 1'b0;
                timeout_fail <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rng_health_monitor.sv
// Bench for rng_health_monitor: history-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_rng_health_monitor;

    localparam int NS = 8, RC = 4, AW = 8, AC = 3, TO = 16;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_FAIL = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: main device under test
    logic        a_start, a_clear, a_valid, a_gen, a_sv, a_busy, a_done, a_rct, a_apt, a_tmo;
    logic [15:0] a_word, a_out, a_count;
    // Instance B: longer run, used for the APT window-rollover scenario
    logic        b_start, b_clear, b_valid, b_gen, b_sv, b_busy, b_done, b_rct, b_apt, b_tmo;
    logic [15:0] b_word, b_out, b_count;

    rng_health_monitor #(.DATA_WIDTH(16), .NUM_SAMPLES(NS), .RCT_CUTOFF(RC), .APT_WINDOW(AW),
                         .APT_CUTOFF(AC), .TIMEOUT_CYCLES(TO)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .clear(a_clear), .generate_enable(a_gen),
        .random_in(a_word), .random_valid(a_valid), .sample_out(a_out), .sample_valid(a_sv),
        .sample_count(a_count), .busy(a_busy), .done(a_done), .rct_fail(a_rct),
        .apt_fail(a_apt), .timeout_fail(a_tmo));

    rng_health_monitor #(.DATA_WIDTH(16), .NUM_SAMPLES(16), .RCT_CUTOFF(RC), .APT_WINDOW(AW),
                         .APT_CUTOFF(AC), .TIMEOUT_CYCLES(TO)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .clear(b_clear), .generate_enable(b_gen),
        .random_in(b_word), .random_valid(b_valid), .sample_out(b_out), .sample_valid(b_sv),
        .sample_count(b_count), .busy(b_busy), .done(b_done), .rct_fail(b_rct),
        .apt_fail(b_apt), .timeout_fail(b_tmo));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: keeps the whole word history of the run and derives the tests from it
    bit          model_ready = 0;
    int          m_state, m_wait, m_count;
    logic [15:0] m_hist[$];
    logic [15:0] m_out;
    bit          m_sv, m_rct, m_apt, m_tmo;

    task automatic model_word(input logic [15:0] w);
        int n, k, ws, m;
        m_hist.push_back(w);
        n = m_hist.size();
        m_wait = 0;
        if (m_count < 65535) m_count++;
        k = 0;
        for (int i = n - 1; i >= 0; i--) begin
            if (m_hist[i] == w) k++;
            else break;
        end
        ws = ((n - 1) / AW) * AW;
        m = 0;
        for (int j = ws; j < n; j++) if (m_hist[j] == m_hist[ws]) m++;
        if (k >= RC || m >= AC) begin
            if (k >= RC) m_rct = 1;
            if (m >= AC) m_apt = 1;
            m_state = M_FAIL;
        end else begin
            m_out = w;
            m_sv  = 1;
            if (n == NS) m_state = M_DONE;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            m_sv = 0;
            if (!rst_n) begin
                m_state = M_IDLE; m_hist.delete(); m_wait = 0; m_count = 0; m_out = '0;
                m_rct = 0; m_apt = 0; m_tmo = 0; model_ready = 1;
            end else begin
                case (m_state)
                    M_IDLE: if (a_start) begin
                        m_state = M_RUN; m_hist.delete(); m_wait = 0; m_count = 0;
                    end
                    M_RUN: if (a_valid) model_word(a_word);
                           else begin
                               m_wait++;
                               if (m_wait == TO) begin m_tmo = 1; m_state = M_FAIL; end
                           end
                    M_DONE: m_state = M_IDLE;
                    default: if (a_clear) begin
                        m_state = M_IDLE; m_rct = 0; m_apt = 0; m_tmo = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ready) begin
                chk("sample_out", a_out, m_out);
                chk("sample_valid", a_sv, m_sv);
                chk("sample_count", a_count, m_count);
                chk("busy", a_busy, m_state == M_RUN);
                chk("generate_enable", a_gen, m_state == M_RUN);
                chk("done", a_done, m_state == M_DONE);
                chk("rct_fail", a_rct, m_rct);
                chk("apt_fail", a_apt, m_apt);
                chk("timeout_fail", a_tmo, m_tmo);
            end
        end
    end

    int          done_cnt = 0;
    logic [15:0] out_q[$];
    initial begin
        forever begin
            @(negedge clk);
            if (a_done === 1'b1) done_cnt++;
            if (a_sv === 1'b1) out_q.push_back(a_out);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask
    task automatic a_go();
        a_start = 1; cyc(); a_start = 0;
    endtask
    task automatic a_feed(input logic [15:0] w);
        a_valid = 1; a_word = w; cyc(); a_valid = 0;
    endtask
    task automatic b_feed(input logic [15:0] w);
        b_valid = 1; b_word = w; cyc(); b_valid = 0;
    endtask
    task automatic a_do_clear();
        a_clear = 1; cyc(); a_clear = 0; cyc();
    endtask

    initial begin
        int done_base, busy_cycles;
        logic [15:0] apt_seq[10];
        apt_seq = '{16'd7, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd8, 16'd7, 16'd7};

        // Reset held with start and valid asserted
        rst_n = 0; a_start = 1; a_clear = 0; a_valid = 1; a_word = 16'h1234;
        b_start = 1; b_clear = 0; b_valid = 1; b_word = 16'h1234;
        repeat (3) cyc();
        chk("rst gen_a", a_gen, 0);
        chk("rst count_a", a_count, 0);
        chk("rst flags_a", {a_rct, a_apt, a_tmo, a_sv, a_done, a_busy}, 0);
        chk("rst gen_b", b_gen, 0);
        chk("rst flags_b", {b_rct, b_apt, b_tmo, b_sv, b_done, b_busy}, 0);
        rst_n = 1; a_start = 0; a_valid = 0; b_start = 0; b_valid = 0;
        cyc();

        // Clean run 1..8 with a stray start mid-run, then trailing words in DONE/IDLE
        out_q.delete(); done_base = done_cnt;
        a_go();
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) a_start = 1;
            a_feed(16'(i));
            a_start = 0;
        end
        a_valid = 1; a_word = 16'd99;
        repeat (3) cyc();
        a_valid = 0; cyc();
        chk("clean done pulses", done_cnt - done_base, 1);
        chk("clean forwarded", out_q.size(), 8);
        for (int i = 0; i < 8 && i < out_q.size(); i++) chk("clean word", out_q[i], i + 1);
        chk("clean count", a_count, 8);
        chk("clean flags", {a_rct, a_apt, a_tmo}, 0);

        // RCT: 5,A,A,A,A
        out_q.delete();
        a_go();
        a_feed(16'h5);
        repeat (4) a_feed(16'hA);
        cyc();
        chk("rct flag", a_rct, 1);
        chk("rct other flags", {a_apt, a_tmo}, 0);
        chk("rct forwarded", out_q.size(), 4);
        chk("rct gen", a_gen, 0);
        a_do_clear();
        chk("rct cleared", {a_rct, a_apt, a_tmo, a_busy}, 0);

        // APT: 7,1,7,2,7
        out_q.delete();
        a_go();
        a_feed(16'd7); a_feed(16'd1); a_feed(16'd7); a_feed(16'd2); a_feed(16'd7);
        cyc();
        chk("apt flag", a_apt, 1);
        chk("apt rct", a_rct, 0);
        chk("apt forwarded", out_q.size(), 4);
        a_do_clear();

        // Timeout: no valid at all
        a_go();
        busy_cycles = 0;
        for (int i = 0; i < 40 && a_tmo !== 1'b1; i++) begin
            if (a_busy === 1'b1) busy_cycles++;
            cyc();
        end
        chk("timeout flag", a_tmo, 1);
        chk("timeout run cycles", busy_cycles, 16);
        a_do_clear();
        chk("timeout cleared", {a_rct, a_apt, a_tmo, a_busy, a_gen}, 0);

        // Reset in place of the last word of a run
        done_base = done_cnt;
        a_go();
        for (int i = 1; i <= 7; i++) a_feed(16'(i));
        rst_n = 0; a_valid = 1; a_word = 16'd8;
        cyc();
        rst_n = 1; a_valid = 0;
        repeat (12) cyc();
        chk("midrst done", done_cnt - done_base, 0);
        chk("midrst count", a_count, 0);
        chk("midrst out", a_out, 0);
        chk("midrst busy", a_busy, 0);

        // RCT failure on the final word of the run
        done_base = done_cnt;
        a_go();
        a_feed(16'd1); a_feed(16'd2); a_feed(16'd3); a_feed(16'd4);
        repeat (4) a_feed(16'd6);
        repeat (3) cyc();
        chk("lastrct flag", a_rct, 1);
        chk("lastrct done", done_cnt - done_base, 0);
        chk("lastrct count", a_count, 8);
        chk("lastrct busy", {a_busy, a_gen}, 0);
        a_do_clear();

        // APT window rollover on B: 7,1,2,3,4,5,6,8 then 7,7 passes; one more 7 fails
        b_start = 1; cyc(); b_start = 0;
        for (int i = 0; i < 10; i++) b_feed(apt_seq[i]);
        chk("win apt clear", b_apt, 0);
        chk("win busy", b_busy, 1);
        chk("win count", b_count, 10);
        b_feed(16'd7);
        chk("win apt flag", b_apt, 1);
        chk("win fail state", b_busy, 0);
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
